// File: rtl/sd_block_buffer_pkg.sv
// Shared definitions for the SD block ping-pong buffer: sizing, fill FSM states and CRC16-CCITT constants.
package sd_block_buffer_pkg;

    localparam int          WORDS_PER_BLOCK_DEFAULT = 128;
    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_INIT    = 16'h0000;
    localparam logic [7:0]  START_TOKEN = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_CRC,
        COMMIT
    } fill_state_t;

    // One byte of CRC16-CCITT, MSB first, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc16_word.sv
// Combinational CRC16-CCITT step absorbing one big-endian 32-bit word (byte [31:24] first).
module sd_crc16_word
    import sd_block_buffer_pkg::*;
(
    input  logic [15:0] crcIn,
    input  logic [31:0] data,
    output logic [15:0] crcOut
);

    assign crcOut = crc16_byte(crc16_byte(crc16_byte(crc16_byte(crcIn, data[31:24]),
                                                     data[23:16]),
                                          data[15:8]),
                               data[7:0]);

endmodule

// File: rtl/sd_block_buffer.sv
// Ping-pong 512-byte sector buffer between the SD SPI block reader and a byte-addressed consumer.
// CRC checking is built only when SD_BLOCK_CRC_CHECK_EN is defined; otherwise every block is good.
module sd_block_buffer
    import sd_block_buffer_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEFAULT,
    localparam int ADDR_W = $clog2(WORDS_PER_BLOCK * 4)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              blockStart,
    input  logic              wordValid,
    input  logic [31:0]       wordIn,
    input  logic              crcValid,
    input  logic [15:0]       crcIn,
    input  logic              blockAbort,
    output logic              fillReady,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [7:0]        rdData,
    output logic              blockAvail,
    output logic              blockGood,
    input  logic              blockRelease,
    output logic [7:0]        blockCount,
    output logic [7:0]        crcErrCount
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    fill_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              fill_ptr;
    logic              rd_ptr;
    logic [1:0]        bank_full;
    logic [1:0]        bank_good;
    logic              commit_good;
    logic              crc_match;
    logic              start_ok;
    logic              release_ok;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [31:0]       mem [2][WORDS_PER_BLOCK];

    // Banks are committed and released strictly alternately, so the bank at fill_ptr is the only candidate to fill.
    assign start_ok   = blockStart && !bank_full[fill_ptr];
    assign release_ok = blockRelease && bank_full[rd_ptr];
    assign fillReady  = (state == IDLE) && !bank_full[fill_ptr];
    assign blockAvail = bank_full[rd_ptr];
    assign blockGood  = bank_full[rd_ptr] && bank_good[rd_ptr];

`ifdef SD_BLOCK_CRC_CHECK_EN
    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    sd_crc16_word u_crc (
        .crcIn  (crc_reg),
        .data   (wordIn),
        .crcOut (crc_next)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            crc_reg <= CRC_INIT;
        end else if (state == IDLE && start_ok) begin
            crc_reg <= CRC_INIT;
        end else if (state == FILL && wordValid) begin
            crc_reg <= crc_next;
        end
    end

    assign crc_match = (crc_reg == crcIn);
`else
    logic unused_crc;
    assign unused_crc = ^crcIn;
    assign crc_match  = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            idx         <= '0;
            fill_ptr    <= 1'b0;
            rd_ptr      <= 1'b0;
            bank_full   <= 2'b00;
            bank_good   <= 2'b00;
            commit_good <= 1'b0;
            blockCount  <= 8'h00;
            crcErrCount <= 8'h00;
        end else begin
            if (release_ok) begin
                bank_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if (blockAbort && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            idx   <= '0;
                            state <= FILL;
                        end
                    end
                    FILL: begin
                        if (crcValid) begin
                            state <= IDLE;
                        end else if (wordValid) begin
                            idx <= idx + 1'b1;
                            if (idx == LAST_IDX) begin
                                state <= WAIT_CRC;
                            end
                        end
                    end
                    WAIT_CRC: begin
                        if (wordValid) begin
                            state <= IDLE;
                        end else if (crcValid) begin
                            commit_good <= crc_match;
                            state       <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        bank_full[fill_ptr] <= 1'b1;
                        bank_good[fill_ptr] <= commit_good;
                        fill_ptr            <= ~fill_ptr;
                        blockCount          <= blockCount + 8'd1;
                        if (!commit_good && crcErrCount != 8'hFF) begin
                            crcErrCount <= crcErrCount + 8'd1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && wordValid) begin
            mem[fill_ptr][idx] <= wordIn;
        end
    end

    assign rd_word = mem[rd_ptr][rdAddr[ADDR_W-1:2]];

    always_comb begin
        rd_byte = rd_word[31:24];
        case (rdAddr[1:0])
            2'd0: rd_byte = rd_word[31:24];
            2'd1: rd_byte = rd_word[23:16];
            2'd2: rd_byte = rd_word[15:8];
            2'd3: rd_byte = rd_word[7:0];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdData <= 8'h00;
        end else if (rdEn) begin
            rdData <= blockAvail ? rd_byte : 8'h00;
        end
    end

endmodule

// File: tb/tb_sd_block_buffer.sv
// Self-checking bench for sd_block_buffer: directed block fills with a queue scoreboard for read bytes.
// Expectations follow SD_BLOCK_CRC_CHECK_EN the same way the design does.
module tb_sd_block_buffer;

`ifdef SD_BLOCK_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        blockStart;
    logic        wordValid;
    logic [31:0] wordIn;
    logic        crcValid;
    logic [15:0] crcIn;
    logic        blockAbort;
    logic        fillReady;
    logic        rdEn;
    logic [8:0]  rdAddr;
    logic [7:0]  rdData;
    logic        blockAvail;
    logic        blockGood;
    logic        blockRelease;
    logic [7:0]  blockCount;
    logic [7:0]  crcErrCount;

    int          checks = 0;
    int          fails  = 0;
    int          exp_count = 0;
    logic [7:0]  exp_q[$];

    sd_block_buffer dut (
        .clk          (clk),
        .resetN       (resetN),
        .blockStart   (blockStart),
        .wordValid    (wordValid),
        .wordIn       (wordIn),
        .crcValid     (crcValid),
        .crcIn        (crcIn),
        .blockAbort   (blockAbort),
        .fillReady    (fillReady),
        .rdEn         (rdEn),
        .rdAddr       (rdAddr),
        .rdData       (rdData),
        .blockAvail   (blockAvail),
        .blockGood    (blockGood),
        .blockRelease (blockRelease),
        .blockCount   (blockCount),
        .crcErrCount  (crcErrCount)
    );

    always #5 clk = ~clk;

    // Byte at address a of a block is seed+a, so every read has an independent expected value.
    function automatic logic [31:0] word_at(input int seed, input int i);
        return {8'(seed + 4*i), 8'(seed + 4*i + 1), 8'(seed + 4*i + 2), 8'(seed + 4*i + 3)};
    endfunction

    function automatic logic [15:0] crc_model(input int seed, input int nwords);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'h0000;
        for (int a = 0; a < 4*nwords; a++) begin
            b = 8'(seed + a);
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        wordValid = 1'b1;
        wordIn    = w;
        step();
        wordValid = 1'b0;
    endtask

    task automatic fill_block(input int seed, input int nwords);
        blockStart = 1'b1;
        step();
        blockStart = 1'b0;
        for (int i = 0; i < nwords; i++) send_word(word_at(seed, i));
    endtask

    task automatic send_crc(input logic [15:0] c);
        crcValid = 1'b1;
        crcIn    = c;
        step();
        crcValid = 1'b0;
    endtask

    // Full good block: fill, CRC, then the COMMIT cycle.
    task automatic commit_block(input int seed);
        fill_block(seed, 128);
        send_crc(crc_model(seed, 128));
        step();
        exp_count++;
    endtask

    task automatic release_block();
        blockRelease = 1'b1;
        step();
        blockRelease = 1'b0;
    endtask

    task automatic read_byte(input string tag, input logic [8:0] a, input logic [7:0] expected);
        rdEn   = 1'b1;
        rdAddr = a;
        exp_q.push_back(expected);
        step();
        rdEn = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check(tag, rdData, exp_q.pop_front());
        end
    endtask

    initial begin
        resetN = 1'b0; blockStart = 1'b0; wordValid = 1'b0; wordIn = '0;
        crcValid = 1'b0; crcIn = '0; blockAbort = 1'b0; rdEn = 1'b0;
        rdAddr = '0; blockRelease = 1'b0;
        step(); step();
        check("rst_fillReady", fillReady, 1);
        check("rst_rdData", rdData, 0);
        check("rst_blockAvail", blockAvail, 0);
        check("rst_blockGood", blockGood, 0);
        check("rst_blockCount", blockCount, 0);
        check("rst_crcErrCount", crcErrCount, 0);
        resetN = 1'b1;
        step();

        // Good block: latency of commit, then byte reads.
        fill_block(0, 128);
        check("fill_fillReady", fillReady, 0);
        send_crc(crc_model(0, 128));
        check("commit_noavail", blockAvail, 0);
        step();
        exp_count++;
        check("b1_avail", blockAvail, 1);
        check("b1_good", blockGood, 1);
        check("b1_count", blockCount, exp_count);
        check("b1_fillReady", fillReady, 1);
        read_byte("b1_rd0", 9'd0, 8'h00);
        read_byte("b1_rd1", 9'd1, 8'h01);
        read_byte("b1_rd511", 9'd511, 8'hFF);
        check("b1_hold", rdData, 8'hFF);
        release_block();
        check("b1_released", blockAvail, 0);
        read_byte("noavail_rd", 9'd1, 8'h00);

        // Corrupted CRC.
        fill_block(0, 128);
        send_crc(crc_model(0, 128) ^ 16'h0001);
        step();
        exp_count++;
        check("bad_avail", blockAvail, 1);
        check("bad_good", blockGood, CRC_EN ? 0 : 1);
        check("bad_errcount", crcErrCount, CRC_EN ? 1 : 0);
        check("bad_count", blockCount, exp_count);
        release_block();

        // Both banks full: third start ignored, release presents the second block.
        commit_block(10);
        commit_block(20);
        check("two_fillReady", fillReady, 0);
        check("two_count", blockCount, exp_count);
        read_byte("two_rd_first", 9'd0, 8'd10);
        blockStart = 1'b1;
        step();
        blockStart = 1'b0;
        check("third_ignored_ready", fillReady, 0);
        release_block();
        check("rel_avail", blockAvail, 1);
        check("rel_fillReady", fillReady, 1);
        read_byte("rel_rd_second", 9'd0, 8'd20);
        release_block();
        check("rel2_avail", blockAvail, 0);

        // Short block, then overflowing block: both dropped.
        fill_block(30, 64);
        send_crc(crc_model(30, 64));
        check("short_fillReady", fillReady, 1);
        fill_block(31, 128);
        send_word(32'hDEADBEEF);
        check("ovf_fillReady", fillReady, 1);
        send_crc(crc_model(31, 128));
        step();
        check("drop_count", blockCount, exp_count);
        check("drop_avail", blockAvail, 0);

        // Abort mid-fill, then a normal block.
        fill_block(35, 50);
        blockAbort = 1'b1;
        step();
        blockAbort = 1'b0;
        check("abort_fillReady", fillReady, 1);
        check("abort_count", blockCount, exp_count);
        commit_block(40);
        check("after_abort_count", blockCount, exp_count);
        read_byte("after_abort_rd5", 9'd5, 8'd45);

        // Commit coincident with release of the presented block.
        fill_block(50, 128);
        send_crc(crc_model(50, 128));
        blockRelease = 1'b1;
        step();
        blockRelease = 1'b0;
        exp_count++;
        check("coinc_avail", blockAvail, 1);
        check("coinc_count", blockCount, exp_count);
        read_byte("coinc_rd0", 9'd0, 8'd50);
        release_block();

        // Abort wins over a simultaneous crcValid.
        fill_block(60, 128);
        crcValid = 1'b1; crcIn = crc_model(60, 128); blockAbort = 1'b1;
        step();
        crcValid = 1'b0; blockAbort = 1'b0;
        step();
        check("abortcrc_count", blockCount, exp_count);
        check("abortcrc_avail", blockAvail, 0);
        check("abortcrc_fillReady", fillReady, 1);

        // Asynchronous reset in the middle of a fill with a block presented.
        commit_block(70);
        read_byte("pre_reset_rd3", 9'd3, 8'd73);
        fill_block(80, 20);
        #3 resetN = 1'b0;
        #1;
        check("arst_fillReady", fillReady, 1);
        check("arst_rdData", rdData, 0);
        check("arst_avail", blockAvail, 0);
        check("arst_good", blockGood, 0);
        check("arst_count", blockCount, 0);
        check("arst_errcount", crcErrCount, 0);
        step();
        resetN = 1'b1;
        exp_count = 0;
        step();

        // 256 commits wrap the block counter.
        for (int i = 0; i < 256; i++) begin
            commit_block(i);
            if (i == 254) check("wrap_255", blockCount, 8'd255);
            release_block();
        end
        check("wrap_0", blockCount, 8'd0);
        check("wrap_errcount", crcErrCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
